// File: rtl/stage_pkg.sv
// rtl/stage_pkg.sv - shared sizing helpers and defaults for the elastic stage buffer
package stage_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 2;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  typedef logic [$clog2(DEFAULT_DEPTH + 1)-1:0] count_t;

endpackage

// File: rtl/stage_buf_mem.sv
// rtl/stage_buf_mem.sv - DEPTH x WIDTH register array, one write port, async read port
module stage_buf_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic             clk,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // storage is intentionally not reset; validity is tracked by the owner's count
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stage_elastic_buf.sv
// rtl/stage_elastic_buf.sv - elastic valid/ready stage buffer with flush; STAGE_BUF_BYPASS_EN adds empty pass-through
module stage_elastic_buf
  import stage_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [WIDTH-1:0]             s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [WIDTH-1:0]             m_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("stage_elastic_buf: DEPTH must be a power of two and >= 2");
  end

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] rdata;
  logic             empty;
  logic             push;
  logic             push_mem;
  logic             pop_mem;

  assign empty   = (count == '0);
  // ready depends only on registered occupancy and flush, never on m_ready
  assign s_ready = (count != FULL_CNT) & ~flush;
  assign push    = s_valid & s_ready;

`ifdef STAGE_BUF_BYPASS_EN
  logic pass;
  assign pass     = empty & ~flush;
  assign m_valid  = pass ? s_valid : ~empty;
  assign m_data   = pass ? s_data : rdata;
  // a payload consumed straight through never touches storage
  assign push_mem = push & ~(pass & m_ready);
  assign pop_mem  = ~empty & m_ready;
`else
  assign m_valid  = ~empty;
  assign m_data   = rdata;
  assign push_mem = push;
  assign pop_mem  = m_valid & m_ready;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_mem) wr_ptr <= wr_ptr + PW'(1);
      if (pop_mem)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_mem) - CW'(pop_mem);
    end
  end

  stage_buf_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .wen   (push_mem),
    .waddr (wr_ptr),
    .wdata (s_data),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

endmodule
